ai_scheduler: RTL
=================

# ai_scheduler

Sequences the AI targeting accelerator and shares it between two requesters (e.g. two computer-controlled players). Each requester presents a 10x10 fired-cell board and a live-ship mask; the scheduler grants one request at a time, programs the accelerator over its Avalon-MM slave port, starts it, reads back the chosen target cell and returns it to the granted requester. It sits between the game controller logic and the `ai` slave, as the accelerator's only bus master.

## Interface
- `TIMEOUT`, 1024: max cycles any single bus access may stall before abort (only with `AI_SCHED_TIMEOUT_EN`).
- `clock  in  1`: sole clock; everything is rising-edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `req0`, `req1`  in  1 each: request; held high until matching `done`.
- `fired0`, `fired1`  in  100 each: fired board, bit i = cell i (row*10+col).
- `ships0`, `ships1`  in  5 each: live-ship mask.
- `done0`, `done1`  out  1 each: one-cycle completion pulse.
- `target`  out  7: result cell index; valid while any `done` is high.
- `err`  out  1: result invalid; valid with `done`.
- `av_addr`  out  4, `av_write`  out  1, `av_read`  out  1, `av_writedata`  out  32: master request.
- `av_waitrequest`  in  1, `av_readdata`  in  32: slave response.

## Operation
- Accelerator register map: addr 1..4 = fired[31:0], [63:32], [95:64], {28'b0, fired[99:96]}; addr 9 = {27'b0, ships}; write to addr 0 = start; read of addr 0 = result, cell index in bits [6:0].
- States: IDLE, WR_F1, WR_F2, WR_F3, WR_F4, WR_SHIPS, WR_START, RD_RESULT, DONE.
- IDLE: if any req high, grant by round-robin (requester not granted last wins a tie; single requester always wins); latch its `fired`/`ships` into internal registers; record grant; go WR_F1.
- Each WR_* state drives `av_write`=1, its address and data; advances only on a cycle with `av_waitrequest`=0. WR_START writes data 0 to addr 0.
- RD_RESULT drives `av_read`=1, addr 0; on a cycle with `av_waitrequest`=0 capture `av_readdata[6:0]` into `target`; `err`=1 if captured value >99. Accelerator stalls this read while computing.
- DONE: pulse `done` of granted requester for exactly one cycle; return to IDLE.
- Latched inputs used throughout; changes to `fired*`/`ships*` after grant are ignored.
- Requester dropping `req` mid-operation: operation completes, `done` still pulsed.
- Never more than one of `av_write`, `av_read` high; both low in IDLE and DONE.

## Timing
- Reset (reset_n low at a rising edge): state IDLE; `done0`,`done1`,`av_write`,`av_read`,`err`=0; `av_addr`,`av_writedata`,`target`=0; last-grant pointer = requester 1, so requester 0 wins the first tie. Reset mid-transfer abandons it immediately; bus outputs low next cycle.
- Zero-wait slave: req seen in IDLE at edge k; `av_write` high cycles k+1..k+6; `av_read` high cycle k+7; `done` high cycle k+8; IDLE at k+9. Each stalled cycle extends by one.
- Request still/newly high during DONE is considered in the following IDLE cycle (one idle cycle minimum between jobs).
- All outputs registered.

## Configuration
- `AI_SCHED_TIMEOUT_EN` defined: per-access counter reset at each state entry; if `av_waitrequest` stays high for `TIMEOUT` consecutive cycles, drop `av_write`/`av_read`, go DONE with `err`=1, `target`=127.
- Undefined: no counter; scheduler waits indefinitely; timeout never sets `err`.

## Test plan
- req0 only, fired0 bits {0,11,99} set, ships0=5'h1F, zero-wait slave returning 42 -> writes addr1=0x00000801, addr2=0, addr3=0, addr4=0x8, addr9=0x1F, addr0=0; `done0` at k+8, `target`=42, `err`=0.
- req0 and req1 asserted same cycle after reset, both held -> requester 0 served first, then requester 1, then 0; `done0`/`done1` alternate, never same cycle.
- Slave holds waitrequest 50 cycles on the read, returns 7 -> `av_read` held high 51 cycles, `target`=7, `done` exactly one cycle.
- Slave returns 120 -> `done` with `err`=1, `target`=120.
- reset_n low during WR_F3 -> next cycle `av_write`=0, state IDLE, no `done` pulse; fresh req0 then completes normally.
- With `AI_SCHED_TIMEOUT_EN`, `TIMEOUT`=16, waitrequest stuck high on WR_F1 -> after 16 cycles `av_write` drops, `done0` with `err`=1, `target`=127.

Source files
------------

// File: rtl/ai_scheduler.sv
// ai_scheduler
//
// Shares the AI targeting accelerator between two requesters. A granted
// request has its fired board and live-ship mask latched. The scheduler then
// writes them to the accelerator over Avalon-MM, writes the start register,
// reads back the chosen cell and pulses the matching done output.
//
// Ports
//   clock, reset_n            rising-edge clock, synchronous active-low reset
//   req0/req1                 requests, held high until the matching done
//   fired0/fired1 [99:0]      fired board per requester (bit = row*10+col)
//   ships0/ships1 [4:0]       live-ship mask per requester
//   done0/done1               one-cycle completion pulse
//   target [6:0], err         result cell and invalid flag, valid with done
//   av_addr, av_write, av_read, av_writedata     master request
//   av_waitrequest, av_readdata                  slave response
//
// Optional feature: define AI_SCHED_TIMEOUT_EN to abort any bus access that
// stalls for TIMEOUT consecutive cycles (done with err=1, target=127).

module ai_scheduler #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [99:0] fired0,
    input  logic [99:0] fired1,
    input  logic [4:0]  ships0,
    input  logic [4:0]  ships1,
    output logic        done0,
    output logic        done1,
    output logic [6:0]  target,
    output logic        err,
    output logic [3:0]  av_addr,
    output logic        av_write,
    output logic        av_read,
    output logic [31:0] av_writedata,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata
);

    typedef enum logic [3:0] {
        IDLE, WR_F1, WR_F2, WR_F3, WR_F4, WR_SHIPS, WR_START, RD_RESULT, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [99:0] fired_q, fired_d;
    logic [4:0]  ships_q, ships_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err_q, err_d;
    logic [6:0]  target_q, target_d;
    logic [3:0]  av_addr_q, av_addr_d;
    logic        av_write_q, av_write_d;
    logic        av_read_q, av_read_d;
    logic [31:0] av_writedata_q, av_writedata_d;

`ifdef AI_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Only the cell index field of the result register is meaningful.
    logic unused_readdata;
    assign unused_readdata = ^av_readdata[31:7];

    function automatic logic [3:0] addr_of(input state_t s);
        case (s)
            WR_F1:    addr_of = 4'd1;
            WR_F2:    addr_of = 4'd2;
            WR_F3:    addr_of = 4'd3;
            WR_F4:    addr_of = 4'd4;
            WR_SHIPS: addr_of = 4'd9;
            default:  addr_of = 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input state_t s, input logic [99:0] f,
                                            input logic [4:0] sh);
        case (s)
            WR_F1:    data_of = f[31:0];
            WR_F2:    data_of = f[63:32];
            WR_F3:    data_of = f[95:64];
            WR_F4:    data_of = {28'b0, f[99:96]};
            WR_SHIPS: data_of = {27'b0, sh};
            default:  data_of = 32'b0;
        endcase
    endfunction

    function automatic state_t next_access(input state_t s);
        case (s)
            WR_F1:     next_access = WR_F2;
            WR_F2:     next_access = WR_F3;
            WR_F3:     next_access = WR_F4;
            WR_F4:     next_access = WR_SHIPS;
            WR_SHIPS:  next_access = WR_START;
            WR_START:  next_access = RD_RESULT;
            RD_RESULT: next_access = DONE;
            default:   next_access = IDLE;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        fired_d      = fired_q;
        ships_d      = ships_q;
        err_d        = err_q;
        target_d     = target_q;
`ifdef AI_SCHED_TIMEOUT_EN
        cnt_d        = '0;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that was not served last wins.
                    grant_d      = (req0 && req1) ? ~last_grant_q : req1;
                    last_grant_d = grant_d;
                    fired_d      = grant_d ? fired1 : fired0;
                    ships_d      = grant_d ? ships1 : ships0;
                    state_d      = WR_F1;
                end
            end
            WR_F1, WR_F2, WR_F3, WR_F4, WR_SHIPS, WR_START, RD_RESULT: begin
                if (!av_waitrequest) begin
                    state_d = next_access(state_q);
                    if (state_q == RD_RESULT) begin
                        target_d = av_readdata[6:0];
                        err_d    = (av_readdata[6:0] > 7'd99);
                    end
                end
`ifdef AI_SCHED_TIMEOUT_EN
                // cnt_q counts stalled cycles already spent in this access.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = DONE;
                    err_d    = 1'b1;
                    target_d = 7'd127;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        done0_d        = (state_d == DONE) && !grant_d;
        done1_d        = (state_d == DONE) && grant_d;
        av_write_d     = state_d inside {WR_F1, WR_F2, WR_F3, WR_F4, WR_SHIPS, WR_START};
        av_read_d      = (state_d == RD_RESULT);
        av_addr_d      = addr_of(state_d);
        av_writedata_d = data_of(state_d, fired_d, ships_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            grant_q        <= 1'b0;
            done0_q        <= 1'b0;
            done1_q        <= 1'b0;
            err_q          <= 1'b0;
            target_q       <= 7'd0;
            av_addr_q      <= 4'd0;
            av_write_q     <= 1'b0;
            av_read_q      <= 1'b0;
            av_writedata_q <= 32'd0;
`ifdef AI_SCHED_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            done0_q        <= done0_d;
            done1_q        <= done1_d;
            err_q          <= err_d;
            target_q       <= target_d;
            av_addr_q      <= av_addr_d;
            av_write_q     <= av_write_d;
            av_read_q      <= av_read_d;
            av_writedata_q <= av_writedata_d;
`ifdef AI_SCHED_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
        // Latched job data needs no reset; it is reloaded at every grant.
        fired_q <= fired_d;
        ships_q <= ships_d;
    end

    assign done0        = done0_q;
    assign done1        = done1_q;
    assign err          = err_q;
    assign target       = target_q;
    assign av_addr      = av_addr_q;
    assign av_write     = av_write_q;
    assign av_read      = av_read_q;
    assign av_writedata = av_writedata_q;

endmodule
